// File: rtl/led_pattern_checker.sv
// led_pattern_checker
//
// Receiving-end observer for the 16-bit LED chaser bus. It samples the bus,
// locks onto the chase sequence at 0x8000, follows it through its four
// phases and checks every transition against the legal successor. Wrong
// successors and stalled values are flagged, and completed laps are counted.
//
// Ports:
//   clk        in   1   system clock
//   rst_n      in   1   asynchronous active-low reset
//   led        in  16   pattern bus under observation (synchronous to clk)
//   locked     out  1   high while tracking a valid sequence
//   phase      out  3   0 SEARCH, 1 LR, 2 RL, 3 MS, 4 SM
//   err        out  1   one-cycle pulse per detected error
//   err_code   out  2   cause of the last error: 1 sequence, 2 stall (held)
//   err_count  out  8   total errors, saturating at 255
//   lap_done   out  1   one-cycle pulse per completed lap
//   lap_count  out  8   completed laps, wraps modulo 256
//
// Parameter:
//   MAX_HOLD   cycles a value may persist while locked before a stall error
//              is raised; must be at least 2.

module led_pattern_checker #(
  parameter int MAX_HOLD = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] led,
  output logic        locked,
  output logic [2:0]  phase,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [7:0]  err_count,
  output logic        lap_done,
  output logic [7:0]  lap_count
);

  typedef enum logic [2:0] {
    PH_SEARCH = 3'd0,
    PH_LR     = 3'd1,
    PH_RL     = 3'd2,
    PH_MS     = 3'd3,
    PH_SM     = 3'd4
  } phase_e;

  // The hold counter only ever holds values up to MAX_HOLD-1: the cycle in
  // which it would reach MAX_HOLD is the cycle that raises the stall.
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  localparam logic [1:0] CODE_SEQ   = 2'd1;
  localparam logic [1:0] CODE_STALL = 2'd2;

  // Sampling pipeline and tracking state.
  logic [15:0]       led_q, led_p;
  phase_e            state_q, state_d;
  logic [15:0]       exp_q, exp_d;
  phase_e            exp_phase_q, exp_phase_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Registered outputs.
  logic              locked_q, locked_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [7:0]        err_count_q, err_count_d;
  logic              lap_done_q, lap_done_d;
  logic [7:0]        lap_count_q, lap_count_d;

  // Events decided by the next-state logic and consumed by the output logic.
  logic              change;
  logic              seq_err;
  logic              stall_err;
  logic              lap_evt;
  logic [15:0]       succ_val;
  phase_e            succ_phase;

  assign change = (led_q != led_p);

  // Bus sampling: led_q is the value judged this cycle, led_p the one
  // judged before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
      led_p <= '0;
    end else begin
      led_q <= led;
      led_p <= led_q;
    end
  end

  // State register, including the expected-next value and the phase that
  // value belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PH_SEARCH;
      exp_q       <= '0;
      exp_phase_q <= PH_SEARCH;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      exp_phase_q <= exp_phase_d;
      hold_q      <= hold_d;
    end
  end

  // Legal successor of the expected value. The phase field names the phase
  // the successor belongs to, so phase boundaries fall on the first value of
  // the new phase (e.g. 0x0001 is still LR, 0x0002 is RL).
  always_comb begin
    succ_val   = 16'h8000;
    succ_phase = PH_LR;
    case (exp_phase_q)
      PH_LR: begin
        if (exp_q == 16'h0001) begin
          succ_val   = 16'h0002;
          succ_phase = PH_RL;
        end else begin
          succ_val   = {1'b0, exp_q[15:1]};
          succ_phase = PH_LR;
        end
      end
      PH_RL: begin
        if (exp_q == 16'h8000) begin
          succ_val   = 16'h0180;
          succ_phase = PH_MS;
        end else begin
          succ_val   = {exp_q[14:0], 1'b0};
          succ_phase = PH_RL;
        end
      end
      PH_MS: begin
        // Middle-out: upper byte moves left, lower byte moves right.
        if (exp_q == 16'h8001) begin
          succ_val   = 16'h4002;
          succ_phase = PH_SM;
        end else begin
          succ_val   = {exp_q[14:8], 1'b0, 1'b0, exp_q[7:1]};
          succ_phase = PH_MS;
        end
      end
      PH_SM: begin
        // Sides-in: upper byte moves right, lower byte moves left.
        if (exp_q == 16'h0180) begin
          succ_val   = 16'h8000;
          succ_phase = PH_LR;
        end else begin
          succ_val   = {1'b0, exp_q[15:9], exp_q[6:0], 1'b0};
          succ_phase = PH_SM;
        end
      end
      default: begin
        succ_val   = 16'h8000;
        succ_phase = PH_LR;
      end
    endcase
  end

  // Next-state logic: lock in SEARCH, otherwise judge change events against
  // the expected value and watch the hold counter for stalls. A change in
  // the cycle the counter would expire takes priority over the stall.
  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    exp_phase_d = exp_phase_q;
    hold_d      = hold_q;
    seq_err     = 1'b0;
    stall_err   = 1'b0;
    lap_evt     = 1'b0;

    if (state_q == PH_SEARCH) begin
      hold_d = '0;
      if (led_q == 16'h8000) begin
        state_d     = PH_LR;
        exp_d       = 16'h4000;
        exp_phase_d = PH_LR;
      end
    end else if (change) begin
      hold_d = '0;
      if (led_q == exp_q) begin
        state_d     = exp_phase_q;
        exp_d       = succ_val;
        exp_phase_d = succ_phase;
        // 0x8000 expected in LR only ever follows 0x0180 at the end of SM;
        // the lock value itself is consumed in SEARCH.
        lap_evt     = (exp_q == 16'h8000) && (exp_phase_q == PH_LR);
      end else begin
        seq_err = 1'b1;
        state_d = PH_SEARCH;
      end
    end else if (hold_q == HOLD_LAST) begin
      stall_err = 1'b1;
      state_d   = PH_SEARCH;
      hold_d    = '0;
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  // Output logic: all outputs are computed from the next-state decisions and
  // registered, so they appear one edge after the judged cycle.
  always_comb begin
    locked_d    = (state_d != PH_SEARCH);
    err_d       = seq_err | stall_err;
    err_code_d  = err_code_q;
    err_count_d = err_count_q;
    lap_done_d  = lap_evt;
    lap_count_d = lap_count_q;

    if (seq_err) begin
      err_code_d = CODE_SEQ;
    end else if (stall_err) begin
      err_code_d = CODE_STALL;
    end

    if ((seq_err || stall_err) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    if (lap_evt) begin
      lap_count_d = lap_count_q + 8'd1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      err_count_q <= '0;
      lap_done_q  <= 1'b0;
      lap_count_q <= '0;
    end else begin
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_count_q <= err_count_d;
      lap_done_q  <= lap_done_d;
      lap_count_q <= lap_count_d;
    end
  end

  assign locked    = locked_q;
  assign phase     = state_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign err_count = err_count_q;
  assign lap_done  = lap_done_q;
  assign lap_count = lap_count_q;

endmodule

// File: tb/tb_led_pattern_checker.sv
// tb_led_pattern_checker
//
// Directed bench for led_pattern_checker: clean laps, garbage while
// searching, sequence and stall errors, error-count saturation and a
// mid-lap reset. Inputs are driven 1 ns after the rising edge, and outputs
// are sampled at the same point.

module tb_led_pattern_checker;

  localparam int MAX_HOLD = 200;

  logic        clk;
  logic        rst_n;
  logic [15:0] led;
  logic        locked;
  logic [2:0]  phase;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;
  logic        lap_done;
  logic [7:0]  lap_count;

  int checks     = 0;
  int errors     = 0;
  int lap_pulses = 0;
  int err_pulses = 0;

  logic [15:0] lap_seq [46];

  led_pattern_checker #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led       (led),
    .locked    (locked),
    .phase     (phase),
    .err       (err),
    .err_code  (err_code),
    .err_count (err_count),
    .lap_done  (lap_done),
    .lap_count (lap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n && lap_done) lap_pulses++;
    if (rst_n && err)      err_pulses++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] value, input int n);
    led = value;
    tick(n);
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [2:0] phaseOf(input int idx);
    if (idx < 16) return 3'd1;
    if (idx < 31) return 3'd2;
    if (idx < 39) return 3'd3;
    return 3'd4;
  endfunction

  initial begin
    lap_seq = '{16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400,
                16'h0200, 16'h0100, 16'h0080, 16'h0040, 16'h0020, 16'h0010,
                16'h0008, 16'h0004, 16'h0002, 16'h0001,
                16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040,
                16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000,
                16'h2000, 16'h4000, 16'h8000,
                16'h0180, 16'h0240, 16'h0420, 16'h0810, 16'h1008, 16'h2004,
                16'h4002, 16'h8001,
                16'h4002, 16'h2004, 16'h1008, 16'h0810, 16'h0420, 16'h0240,
                16'h0180};

    // Reset state.
    rst_n = 1'b0;
    led   = 16'h0000;
    tick(3);
    checkOutput("reset_locked",    16'(locked),    16'h0);
    checkOutput("reset_phase",     16'(phase),     16'h0);
    checkOutput("reset_err",       16'(err),       16'h0);
    checkOutput("reset_err_count", 16'(err_count), 16'h0);
    checkOutput("reset_lap_count", 16'(lap_count), 16'h0);
    rst_n = 1'b1;
    tick(2);

    // Garbage while searching: no lock, no errors.
    $display("[TB] garbage while searching");
    applyStimulus(16'h0000, 5);
    applyStimulus(16'h1234, 5);
    applyStimulus(16'h0040, 5);
    checkOutput("garbage_locked",    16'(locked),    16'h0);
    checkOutput("garbage_phase",     16'(phase),     16'h0);
    checkOutput("garbage_err_count", 16'(err_count), 16'h0);
    checkOutput("garbage_err_seen",  16'(err_pulses), 16'h0);

    // Three clean laps, each value held 51 cycles.
    $display("[TB] clean laps");
    for (int lap = 0; lap < 3; lap++) begin
      for (int i = 0; i < 46; i++) begin
        applyStimulus(lap_seq[i], 2);
        checkOutput($sformatf("lap%0d_idx%0d_phase", lap, i), 16'(phase), 16'(phaseOf(i)));
        if (i == 0) begin
          checkOutput($sformatf("lap%0d_lap_done", lap), 16'(lap_done), (lap > 0) ? 16'h1 : 16'h0);
          checkOutput($sformatf("lap%0d_lap_count", lap), 16'(lap_count), 16'(lap));
        end
        tick(49);
      end
    end
    applyStimulus(16'h8000, 2);
    checkOutput("lap3_lap_done",  16'(lap_done),  16'h1);
    checkOutput("lap3_lap_count", 16'(lap_count), 16'h3);
    checkOutput("lap3_phase",     16'(phase),     16'h1);
    tick(1);
    checkOutput("lap3_lap_done_off", 16'(lap_done), 16'h0);
    tick(48);
    checkOutput("clean_lap_pulses", 16'(lap_pulses), 16'h3);
    checkOutput("clean_err_pulses", 16'(err_pulses), 16'h0);
    checkOutput("clean_err_count",  16'(err_count),  16'h0);

    // Sequence error: 0x2000 followed by 0x0800 instead of 0x1000.
    $display("[TB] sequence error");
    applyStimulus(16'h4000, 3);
    applyStimulus(16'h2000, 3);
    applyStimulus(16'h0800, 1);
    checkOutput("seq_err_early", 16'(err), 16'h0);
    tick(1);
    checkOutput("seq_err",       16'(err),       16'h1);
    checkOutput("seq_err_code",  16'(err_code),  16'h1);
    checkOutput("seq_err_count", 16'(err_count), 16'h1);
    checkOutput("seq_phase",     16'(phase),     16'h0);
    checkOutput("seq_locked",    16'(locked),    16'h0);
    tick(1);
    checkOutput("seq_err_pulse_end", 16'(err), 16'h0);
    applyStimulus(16'h8000, 1);
    checkOutput("relock_one_edge", 16'(locked), 16'h0);
    tick(1);
    checkOutput("relock_two_edges", 16'(locked), 16'h1);
    checkOutput("relock_phase",     16'(phase),  16'h1);

    // Stall: hold 0x0100 in LR.
    $display("[TB] stall");
    applyStimulus(16'h4000, 3);
    applyStimulus(16'h2000, 3);
    applyStimulus(16'h1000, 3);
    applyStimulus(16'h0800, 3);
    applyStimulus(16'h0400, 3);
    applyStimulus(16'h0200, 3);
    applyStimulus(16'h0100, MAX_HOLD + 1);
    checkOutput("stall_not_yet",    16'(err),    16'h0);
    checkOutput("stall_still_lock", 16'(locked), 16'h1);
    tick(1);
    checkOutput("stall_err",       16'(err),       16'h1);
    checkOutput("stall_err_code",  16'(err_code),  16'h2);
    checkOutput("stall_err_count", 16'(err_count), 16'h2);
    checkOutput("stall_phase",     16'(phase),     16'h0);
    tick(1);
    checkOutput("stall_pulse_end", 16'(err), 16'h0);

    // Change arriving in the cycle the hold counter would expire.
    $display("[TB] change on expiry cycle");
    applyStimulus(16'h8000, MAX_HOLD);
    applyStimulus(16'h4000, 1);
    tick(1);
    checkOutput("expiry_err",       16'(err),       16'h0);
    checkOutput("expiry_locked",    16'(locked),    16'h1);
    checkOutput("expiry_phase",     16'(phase),     16'h1);
    checkOutput("expiry_err_count", 16'(err_count), 16'h2);

    // Saturation: many sequence errors.
    $display("[TB] error count saturation");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(16'h8000, 1);
      applyStimulus(16'h1234, 1);
    end
    tick(2);
    checkOutput("sat_err_count", 16'(err_count), 16'hFF);
    checkOutput("sat_err_code",  16'(err_code),  16'h1);
    applyStimulus(16'h8000, 2);
    applyStimulus(16'h0001, 2);
    checkOutput("sat_err_pulse", 16'(err),       16'h1);
    checkOutput("sat_hold",      16'(err_count), 16'hFF);

    // Reset mid-MS.
    $display("[TB] reset mid-lap");
    for (int i = 0; i < 33; i++) begin
      applyStimulus(lap_seq[i], 2);
    end
    checkOutput("pre_reset_phase",     16'(phase),     16'h3);
    checkOutput("pre_reset_lap_count", 16'(lap_count), 16'h3);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_locked",    16'(locked),    16'h0);
    checkOutput("rst_phase",     16'(phase),     16'h0);
    checkOutput("rst_err",       16'(err),       16'h0);
    checkOutput("rst_err_code",  16'(err_code),  16'h0);
    checkOutput("rst_err_count", 16'(err_count), 16'h0);
    checkOutput("rst_lap_done",  16'(lap_done),  16'h0);
    checkOutput("rst_lap_count", 16'(lap_count), 16'h0);
    tick(2);
    led   = 16'h1008;
    rst_n = 1'b1;
    tick(10);
    checkOutput("post_rst_locked",    16'(locked),    16'h0);
    checkOutput("post_rst_phase",     16'(phase),     16'h0);
    checkOutput("post_rst_err_count", 16'(err_count), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_pattern_checker.md
# led_pattern_checker

Observer/checker for the 16-bit LED chaser bus; it is the receiving end of the LED pattern generator. It samples `led`, locks onto the chase sequence, and tracks which phase the pattern is in. Every transition is validated against the legal successor, and sequence or stall errors are flagged. It also counts completed laps, so it serves both as a bring-up monitor and as an in-system self-check.

## Interface
- `MAX_HOLD`, default 200: maximum number of cycles a value may persist while locked before a stall error is raised. Must be at least 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `led`  in  16  pattern bus under observation, synchronous to `clk`.
- `locked`  out  1  high while tracking a valid sequence.
- `phase`  out  3  current phase: 0 SEARCH, 1 LR, 2 RL, 3 MS, 4 SM.
- `err`  out  1  one-cycle error pulse.
- `err_code`  out  2  cause of the last error: 1 sequence, 2 stall. Holds its value until the next error.
- `err_count`  out  8  total errors, saturating at 255.
- `lap_done`  out  1  one-cycle pulse per completed lap.
- `lap_count`  out  8  completed laps, wraps modulo 256.

## Operation
- **Legal lap:**
  - LR: 0x8000 → 0x0001, one-hot shifting right (16 values).
  - RL: 0x0002 → 0x8000, shifting left (15 values).
  - MS: 0x0180, 0x0240, 0x0420, 0x0810, 0x1008, 0x2004, 0x4002, 0x8001.
  - SM: 0x4002, 0x2004, 0x1008, 0x0810, 0x0420, 0x0240, 0x0180.
  - The lap then restarts at 0x8000 (LR).
- **Phase boundaries:** RL follows 0x0001. MS follows 0x8000 reached in RL. SM follows 0x8001. LR follows 0x0180 reached in SM.
- **Sampling:** `led_q` <= `led` and `led_p` <= `led_q` every cycle. A change event occurs when `led_q` != `led_p`.
- **SEARCH:** each cycle, if `led_q` == 0x8000, go to LR. The expected next value becomes 0x4000 and the hold counter is cleared. No errors are raised in SEARCH.
- **Locked (LR/RL/MS/SM), change event:**
  - If `led_q` equals the expected value: advance the expected value and phase, and clear the hold counter.
  - On a mismatch: `err`=1, `err_code`=1, `err_count`+1 (saturating), go to SEARCH.
- **Locked, no change event:**
  - The hold counter increments.
  - When it reaches `MAX_HOLD`: `err`=1, `err_code`=2, `err_count`+1, go to SEARCH.
- **Lap completion:** a matching 0x0180 → 0x8000 transition pulses `lap_done` and increments `lap_count`.
- **Simultaneous events:** a change event in the same cycle the hold counter would expire counts as a change (no stall). A mismatching value of 0x8000 still raises the error; SEARCH then relocks on the following cycle, because `led_q` is still 0x8000.
- **Mid-lap entry:** the checker locks only at 0x8000. Entering mid-lap produces no error until lock is acquired.

## Timing
- All outputs are registered.
- **Reset:** all outputs are 0, `phase`=0, and `led_q`, `led_p` and the hold counter are 0. This takes effect immediately on `rst_n` low, including mid-lap.
- **Change-detection latency:** `led` is sampled at edge N into `led_q`. The change is judged during cycle N. `phase`, `err`, `lap_done` and the counters update at edge N+1.
- **Lock latency:** with 0x8000 present at `led` before edge N, `locked` and `phase`=1 are set at edge N+1.
- **Stall timing:** the stall error fires at the edge where the hold counter reaches `MAX_HOLD`, i.e. `MAX_HOLD` cycles after the last judged change.
- `err` and `lap_done` are high for exactly one cycle per event.
- `err_count` does not increment past 255.

## Test plan
- **Clean lap:** reset, then drive a clean lap, each value held 51 cycles, repeated 3 times. Required: `phase` steps 1→2→3→4→1, `lap_done` pulses 3 times, `lap_count`=3, `err` never asserts.
- **Garbage while searching:** drive 0x0000, then 0x1234, then 0x0040. Required: `locked`=0, `phase`=0, `err`=0, `err_count`=0.
- **Sequence error:** lock, then step LR to 0x2000 and drive 0x0800. Required: one `err` pulse, `err_code`=1, `err_count`=1, `phase`=0. Then drive 0x8000. Required: `locked`=1 two edges later.
- **Stall:** lock and hold 0x0100 in LR. Required: `err` exactly 200 cycles after the last judged change, `err_code`=2. Also apply a change on the expiry cycle. Required: no error.
- **Saturation:** force 300 sequence errors. Required: `err_count`=255.
- **Reset mid-lap:** assert `rst_n`=0 mid-MS. Required: all outputs 0 immediately. After release, with 0x1008 held, the checker stays in SEARCH.
